// File: rtl/register_transfer_sequencer_pkg.sv
// Shared definitions for the register transfer sequencer: register indices, bus layout, FSM encoding.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package register_transfer_sequencer_pkg;

  localparam int NUM_REGS = 6;

  localparam logic [2:0] REG_A  = 3'd0;
  localparam logic [2:0] REG_B  = 3'd1;
  localparam logic [2:0] REG_C  = 3'd2;
  localparam logic [2:0] REG_P  = 3'd3;
  localparam logic [2:0] REG_S  = 3'd4;
  localparam logic [2:0] REG_ST = 3'd5;

  localparam logic [2:0] SRC_ILLEGAL = 3'd6;
  localparam logic [2:0] SRC_EXT     = 3'd7;

  localparam int LOAD_LSB = 0;
  localparam int OE_LSB   = NUM_REGS;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_LOAD  = 2'd2;
  localparam logic [1:0] ST_TURN  = 2'd3;

  typedef struct packed {
    logic [2:0]          src;
    logic [NUM_REGS-1:0] dst;
  } xfer_req_t;

  // Output-enable one-hot for a register source; external/illegal codes map to zero.
  function automatic logic [NUM_REGS-1:0] oe_onehot(input logic [2:0] src);
    logic [NUM_REGS-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      oh[i] = (src == 3'(i));
    end
    return oh;
  endfunction

endpackage

// File: rtl/register_transfer_sequencer_transfer_request_slot.sv
// One-entry holding register queueing a transfer request while another is in flight.
// Latency: push visible as full on the next edge.
// Backpressure: caller must not push while full unless popping in the same cycle.
module transfer_request_slot
  import register_transfer_sequencer_pkg::*;
(
  input  logic      clock_in,
  input  logic      reset_in,
  input  logic      push,
  input  xfer_req_t push_dat,
  input  logic      pop,
  output logic      full,
  output xfer_req_t dat
);

  // A push in the same cycle as a pop refills the entry that was just freed.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      full <= 1'b0;
      dat  <= '0;
    end else if (push) begin
      full <= 1'b1;
      dat  <= push_dat;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/register_transfer_sequencer.sv
// Sequences register-to-register transfers on the shared bus: DRIVE -> LOAD -> TURN.
// Latency: accept at edge N gives DRIVE from N+1, LOAD at N+1+SETTLE_CYCLES, TURN one cycle later.
// Backpressure: req_ready drops while the holding slot is full, except in TURN where the slot pops.
module register_transfer_sequencer
  import register_transfer_sequencer_pkg::*;
#(
  parameter int NREG          = NUM_REGS,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clock_in,
  input  logic              reset_in,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_src,
  input  logic [NREG-1:0]   req_dst,
  output logic [2*NREG-1:0] Register_Control_Bus,
  output logic              ext_drive_en,
  output logic              busy,
  output logic              xfer_done,
  output logic              req_err
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  logic [1:0]        state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  xfer_req_t         work, work_nxt;
  xfer_req_t         in_req, slot_dat;
  logic              slot_full, slot_full_nxt, slot_push, slot_pop;
  logic              accept, legal;
  logic [2*NREG-1:0] bus_nxt;
  logic              ext_nxt;

  assign in_req        = '{src: req_src, dst: req_dst};
  assign accept        = req_valid && req_ready;
  assign legal         = (req_src != SRC_ILLEGAL) && (req_dst != '0);
  assign slot_push     = accept && legal;
  assign slot_full_nxt = slot_push || (slot_full && !slot_pop);

  transfer_request_slot u_slot (
    .clock_in (clock_in),
    .reset_in (reset_in),
    .push     (slot_push),
    .push_dat (in_req),
    .pop      (slot_pop),
    .full     (slot_full),
    .dat      (slot_dat)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    work_nxt  = work;
    slot_pop  = 1'b0;
    case (state)
      ST_IDLE, ST_TURN: begin
        if (slot_full) begin
          state_nxt = ST_DRIVE;
          work_nxt  = slot_dat;
          cnt_nxt   = SETTLE_LOAD;
          slot_pop  = 1'b1;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        if (cnt == 4'd0) state_nxt = ST_LOAD;
        else             cnt_nxt   = cnt - 4'd1;
      end
      ST_LOAD:  state_nxt = ST_TURN;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are encoded from the next state so the registered bus lines up with the FSM.
  always_comb begin
    bus_nxt = '0;
    ext_nxt = 1'b0;
    if (state_nxt == ST_DRIVE || state_nxt == ST_LOAD) begin
      if (work_nxt.src == SRC_EXT) ext_nxt = 1'b1;
      else                         bus_nxt[OE_LSB +: NREG] = oe_onehot(work_nxt.src);
      if (state_nxt == ST_LOAD)    bus_nxt[LOAD_LSB +: NREG] = work_nxt.dst;
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state                <= ST_IDLE;
      cnt                  <= '0;
      work                 <= '0;
      Register_Control_Bus <= '0;
      ext_drive_en         <= 1'b0;
      busy                 <= 1'b0;
      xfer_done            <= 1'b0;
      req_err              <= 1'b0;
      req_ready            <= 1'b1;
    end else begin
      state                <= state_nxt;
      cnt                  <= cnt_nxt;
      work                 <= work_nxt;
      Register_Control_Bus <= bus_nxt;
      ext_drive_en         <= ext_nxt;
      busy                 <= (state_nxt != ST_IDLE) || slot_full_nxt;
      xfer_done            <= (state_nxt == ST_TURN);
      req_err              <= accept && !legal;
      // TURN always pops a full slot, so a new request can land in it that same cycle.
      req_ready            <= !slot_full_nxt || (state_nxt == ST_TURN);
    end
  end

endmodule

// File: tb/tb_register_transfer_sequencer.sv
// Directed bench for register_transfer_sequencer with a small register-file model.
// Latency: n/a. Backpressure: requests are held until req_ready is seen.
module tb_register_transfer_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          n_checks = 0;
  int          n_fail = 0;

  logic        valid1 = 1'b0, ready1, ext1, busy1, done1, err1;
  logic [2:0]  src1 = '0;
  logic [5:0]  dst1 = '0;
  logic [11:0] bus1;

  logic        valid3 = 1'b0, ready3, ext3, busy3, done3, err3;
  logic [2:0]  src3 = '0;
  logic [5:0]  dst3 = '0;
  logic [11:0] bus3;

  logic [7:0]  rf [6];

  always #5 clk = ~clk;

  register_transfer_sequencer #(.NREG(6), .SETTLE_CYCLES(1)) u1 (
    .clock_in(clk), .reset_in(rst), .req_valid(valid1), .req_ready(ready1),
    .req_src(src1), .req_dst(dst1), .Register_Control_Bus(bus1),
    .ext_drive_en(ext1), .busy(busy1), .xfer_done(done1), .req_err(err1));

  register_transfer_sequencer #(.NREG(6), .SETTLE_CYCLES(3)) u3 (
    .clock_in(clk), .reset_in(rst), .req_valid(valid3), .req_ready(ready3),
    .req_src(src3), .req_dst(dst3), .Register_Control_Bus(bus3),
    .ext_drive_en(ext3), .busy(busy3), .xfer_done(done3), .req_err(err3));

  initial begin
    for (int i = 0; i < 6; i++) rf[i] = 8'h10 + 8'(i);
  end

  // Register-file model captures on the falling edge inside LOAD; also bus invariants.
  always @(negedge clk) begin
    logic [7:0] d;
    d = 8'h00;
    if (bus1[5:0] != 6'd0) begin
      if (ext1) d = 8'hE7;
      for (int i = 0; i < 6; i++) if (bus1[6+i]) d = rf[i];
      for (int i = 0; i < 6; i++) if (bus1[i]) rf[i] = d;
    end
    n_checks++;
    if ($countones(bus1[11:6]) > 1 || (ext1 && bus1[11:6] != 0) ||
        (bus1[5:0] != 0 && bus1[11:6] == 0 && !ext1)) begin
      n_fail++; $display("FAIL invariant_u1: bus=%h ext=%b", bus1, ext1);
    end
    n_checks++;
    if ($countones(bus3[11:6]) > 1 || (ext3 && bus3[11:6] != 0) ||
        (bus3[5:0] != 0 && bus3[11:6] == 0 && !ext3)) begin
      n_fail++; $display("FAIL invariant_u3: bus=%h ext=%b", bus3, ext3);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send1(input logic [2:0] s, input logic [5:0] d);
    n_checks++;
    if (ready1 !== 1'b1) begin n_fail++; $display("FAIL send_ready: got %b expected 1", ready1); end
    valid1 = 1'b1; src1 = s; dst1 = d;
    tick();
    valid1 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_checks++; if (bus1 !== 12'h000) begin n_fail++; $display("FAIL rst_bus: got %h expected 000", bus1); end
    n_checks++; if (ext1 !== 1'b0)    begin n_fail++; $display("FAIL rst_ext: got %b expected 0", ext1); end
    n_checks++; if (busy1 !== 1'b0)   begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy1); end
    n_checks++; if (done1 !== 1'b0)   begin n_fail++; $display("FAIL rst_done: got %b expected 0", done1); end
    n_checks++; if (err1 !== 1'b0)    begin n_fail++; $display("FAIL rst_err: got %b expected 0", err1); end
    n_checks++; if (ready1 !== 1'b1)  begin n_fail++; $display("FAIL rst_ready: got %b expected 1", ready1); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    n_checks++; if (rf[1] !== 8'h11) begin n_fail++; $display("FAIL basic_pre_b: got %h expected 11", rf[1]); end
    send1(3'd0, 6'b000010);
    n_checks++; if (ready1 !== 1'b0 || busy1 !== 1'b1) begin n_fail++; $display("FAIL basic_n0: ready=%b busy=%b expected 0 1", ready1, busy1); end
    tick();
    n_checks++; if (bus1 !== 12'h040) begin n_fail++; $display("FAIL basic_drive: got %h expected 040", bus1); end
    tick();
    n_checks++; if (bus1 !== 12'h042) begin n_fail++; $display("FAIL basic_load: got %h expected 042", bus1); end
    tick();
    n_checks++; if (bus1 !== 12'h000 || done1 !== 1'b1) begin n_fail++; $display("FAIL basic_turn: bus=%h done=%b expected 000 1", bus1, done1); end
    tick();
    n_checks++; if (done1 !== 1'b0 || busy1 !== 1'b0) begin n_fail++; $display("FAIL basic_idle: done=%b busy=%b expected 0 0", done1, busy1); end
    n_checks++; if (rf[1] !== 8'h10) begin n_fail++; $display("FAIL basic_b_eq_a: got %h expected 10", rf[1]); end
  endtask

  task automatic test_ext();
    logic [11:0] eb [3];
    logic        ee [3];
    logic        ed [3];
    eb = '{12'h000, 12'h005, 12'h000};
    ee = '{1'b1, 1'b1, 1'b0};
    ed = '{1'b0, 1'b0, 1'b1};
    send1(3'd7, 6'b000101);
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (bus1 !== eb[k] || ext1 !== ee[k] || done1 !== ed[k]) begin
        n_fail++; $display("FAIL ext_cycle%0d: bus=%h ext=%b done=%b expected %h %b %b", k, bus1, ext1, done1, eb[k], ee[k], ed[k]);
      end
    end
    tick();
    n_checks++; if (rf[0] !== 8'hE7 || rf[2] !== 8'hE7) begin n_fail++; $display("FAIL ext_load: A=%h C=%h expected e7 e7", rf[0], rf[2]); end
  endtask

  task automatic test_reject();
    logic [2:0] rs [2];
    logic [5:0] rd [2];
    rs = '{3'd6, 3'd2};
    rd = '{6'b000001, 6'b000000};
    for (int j = 0; j < 2; j++) begin
      send1(rs[j], rd[j]);
      n_checks++;
      if (err1 !== 1'b1 || bus1 !== 12'h000 || busy1 !== 1'b0 || ready1 !== 1'b1) begin
        n_fail++; $display("FAIL reject%0d_pulse: err=%b bus=%h busy=%b ready=%b expected 1 000 0 1", j, err1, bus1, busy1, ready1);
      end
      tick();
      n_checks++;
      if (err1 !== 1'b0 || bus1 !== 12'h000 || busy1 !== 1'b0) begin
        n_fail++; $display("FAIL reject%0d_after: err=%b bus=%h busy=%b expected 0 000 0", j, err1, bus1, busy1);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  qs [3];
    logic [5:0]  qd [3];
    logic [11:0] eb [11];
    logic        ed [11];
    logic        er [11];
    logic        ey [11];
    int          nxt;
    logic        acc;
    qs = '{3'd3, 3'd4, 3'd5};
    qd = '{6'b000001, 6'b100000, 6'b000100};
    eb = '{12'h000, 12'h200, 12'h201, 12'h000, 12'h400, 12'h420, 12'h000, 12'h800, 12'h804, 12'h000, 12'h000};
    ed = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0};
    er = '{0, 1, 0, 1, 0, 0, 1, 1, 1, 1, 1};
    ey = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    send1(qs[0], qd[0]);
    nxt = 1;
    for (int t = 0; t < 11; t++) begin
      n_checks++;
      if (bus1 !== eb[t] || done1 !== ed[t] || ready1 !== er[t] || busy1 !== ey[t]) begin
        n_fail++; $display("FAIL b2b_t%0d: bus=%h done=%b ready=%b busy=%b expected %h %b %b %b",
                           t, bus1, done1, ready1, busy1, eb[t], ed[t], er[t], ey[t]);
      end
      valid1 = (nxt < 3);
      if (nxt < 3) begin src1 = qs[nxt]; dst1 = qd[nxt]; end
      acc = valid1 && ready1;
      tick();
      if (acc) nxt++;
    end
    valid1 = 1'b0;
    n_checks++; if (nxt != 3) begin n_fail++; $display("FAIL b2b_accepts: got %0d expected 3", nxt); end
    n_checks++;
    if (rf[0] !== 8'h13 || rf[5] !== 8'h14 || rf[2] !== 8'h14) begin
      n_fail++; $display("FAIL b2b_regs: A=%h ST=%h C=%h expected 13 14 14", rf[0], rf[5], rf[2]);
    end
  endtask

  task automatic test_settle();
    logic [11:0] eb [6];
    logic        ed [6];
    eb = '{12'h000, 12'h080, 12'h080, 12'h080, 12'h081, 12'h000};
    ed = '{0, 0, 0, 0, 0, 1};
    n_checks++; if (ready3 !== 1'b1) begin n_fail++; $display("FAIL settle_ready: got %b expected 1", ready3); end
    valid3 = 1'b1; src3 = 3'd1; dst3 = 6'b000001;
    tick();
    valid3 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (bus3 !== eb[k] || done3 !== ed[k] || ext3 !== 1'b0 || err3 !== 1'b0) begin
        n_fail++; $display("FAIL settle_n%0d: bus=%h done=%b ext=%b err=%b expected %h %b 0 0", k, bus3, done3, ext3, err3, eb[k], ed[k]);
      end
      tick();
    end
    n_checks++; if (busy3 !== 1'b0) begin n_fail++; $display("FAIL settle_idle: busy=%b expected 0", busy3); end
  endtask

  task automatic test_reset_mid();
    send1(3'd0, 6'b000010);
    tick();
    send1(3'd1, 6'b000100);
    n_checks++; if (bus1 !== 12'h042 || busy1 !== 1'b1) begin n_fail++; $display("FAIL rmid_load: bus=%h busy=%b expected 042 1", bus1, busy1); end
    rst = 1'b1;
    tick();
    n_checks++;
    if (bus1 !== 12'h000 || busy1 !== 1'b0 || done1 !== 1'b0 || ext1 !== 1'b0 || ready1 !== 1'b1) begin
      n_fail++; $display("FAIL rmid_reset: bus=%h busy=%b done=%b ext=%b ready=%b expected 000 0 0 0 1", bus1, busy1, done1, ext1, ready1);
    end
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      n_checks++;
      if (bus1 !== 12'h000 || done1 !== 1'b0 || busy1 !== 1'b0) begin
        n_fail++; $display("FAIL rmid_lost%0d: bus=%h done=%b busy=%b expected 000 0 0", k, bus1, done1, busy1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ext();
    test_reject();
    test_back_to_back();
    test_settle();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
